id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
Operand-issue half of the decode stage, placed between the instruction decoder and the ID/EX pipeline register.
- Resolves rs/rt operands from the regfile or from a parametrised set of forwarding ports.
- Tracks one in-flight multi-cycle MUL in a single-entry scoreboard.
- Stalls on unresolved hazards and on EX backpressure, registers the issued bundle, and counts stall cycles for the monitor.

Parameters:
DATA_W, 32, operand/register word width
RA_W, 5, register address width
NUM_FWD, 3, number of forwarding ports; index 0 = youngest, highest priority
MUL_LAT, 3, cycles from MUL issue until its result is on a forwarding port (>=1)
STALL_CNT_W, 16, stall counter width

Ports:
cpu_clk  in  1  clock
cpu_rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decoded instruction present
id_ready  out  1  instruction accepted this cycle
id_pc  in  DATA_W  instruction PC
id_rs, id_rt  in  RA_W  source register addresses
id_use_rs, id_use_rt  in  1  source actually read
id_wa  in  RA_W  destination register
id_we  in  1  instruction writes a register
id_is_load, id_is_mul  in  1  class flags
id_imm_sel  in  1  src2 = id_imm instead of rt data
id_imm  in  DATA_W  pre-extended immediate
rf_read_add1, rf_read_add2  out  RA_W  = id_rs, id_rt
rf_read_data1, rf_read_data2  in  DATA_W  combinational regfile data
fwd_we  in  NUM_FWD  per-port write enable
fwd_wa  in  NUM_FWD*RA_W  per-port write address (port i at [i*RA_W +: RA_W])
fwd_wd  in  NUM_FWD*DATA_W  per-port write data
fwd_rdy  in  NUM_FWD  per-port data valid (0 = load not yet returned)
flush  in  1  squash issue and ID/EX contents
ex_ready  in  1  EX accepts bundle
ex_valid  out  1  bundle valid
ex_pc, ex_src1, ex_src2  out  DATA_W  issued PC and operands
ex_wa  out  RA_W  issued destination
ex_we, ex_is_load, ex_is_mul  out  1  issued flags
stall_cause  out  2  0 none, 1 data, 2 mul scoreboard, 3 backpressure
stall_cnt  out  STALL_CNT_W  saturating stall-cycle count

Behaviour:
Reset:
- All ex_* outputs and stall_cnt are 0. stall_cause is 0. Scoreboard is empty (mul_cnt=0).

Operand resolution (combinational), per source s in {rs, rt}:
- s==0 -> value 0, never a hazard.
- Otherwise scan ports 0..NUM_FWD-1. The first port with fwd_we && fwd_wa==s is the match.
- Match with fwd_rdy=1 -> fwd_wd. Match with fwd_rdy=0 -> data hazard, but only if id_use_s.
- No match -> rf data.

Operand mapping:
- ex_src1 <= rs value.
- ex_src2 <= id_imm_sel ? id_imm : rt value.

Scoreboard (one entry: mul_wa, mul_cnt):
- busy = mul_cnt != 0.
- mul hazard when busy and any of:
  - id_use_rs && id_rs==mul_wa && mul_wa!=0
  - id_use_rt && id_rt==mul_wa && mul_wa!=0
  - id_we && id_wa==mul_wa (WAW)
  - id_is_mul (structural; only one MUL in flight)

Issue:
- ex_free = !ex_valid || ex_ready.
- id_ready = ex_free && !data_hazard && !mul_hazard && !flush.
- fire = id_valid && id_ready.
- At the edge on fire: load the bundle and set ex_valid=1.
- Else if ex_ready or flush: ex_valid=0.
- While ex_valid && !ex_ready, all ex_* outputs hold.
- Latency: one cycle from accept to ex_valid.

Scoreboard update, each edge:
- flush -> mul_cnt=0.
- Else fire && id_is_mul && id_we && id_wa!=0 -> mul_wa=id_wa, mul_cnt=MUL_LAT.
- Else if busy -> mul_cnt decrements by 1.
- Consequence: a dependent instruction accepted directly after the MUL stalls exactly MUL_LAT cycles.

Flush:
- Forces id_ready=0 in that cycle.
- Clears ex_valid and the scoreboard at the next edge.
- If flush and a MUL fire would coincide, flush wins and no scoreboard load happens.

stall_cause (when id_valid && !id_ready && !flush), priority order:
- backpressure (!ex_free) = 3
- data hazard = 1
- mul hazard = 2
- Otherwise 0.

stall_cnt:
- Increments each cycle stall_cause != 0.
- Saturates at 2^STALL_CNT_W-1.
- Reset is the only clear.

Reset mid-operation:
- Immediately clears all state regardless of pending handshake.

Test Plan:
1. Forward priority: fwd0 (we, wa=5, wd=0x11, rdy) and fwd1 (we, wa=5, wd=0x22, rdy); issue rs=5 -> next cycle ex_valid=1, ex_src1=0x11.
2. Load-use: fwd0 wa=8, rdy=0; issue use_rs, rs=8.
   - Required: id_ready=0, stall_cause=1, stall_cnt +1 per cycle.
   - Then rdy=1, wd=0xAB -> fire, ex_src1=0xAB.
3. MUL_LAT=3: MUL wa=9 issues, then a consumer with rs=9.
   - Required: exactly 3 stall cycles with stall_cause=2, then issue.
   - A second MUL presented during the stall also waits.
4. Backpressure: ex_valid=1, ex_ready=0 for 4 cycles with a new id_valid.
   - Required: ex_* outputs unchanged, id_ready=0, stall_cause=3, stall_cnt +4.
5. Zero register: rs=0, fwd0 we wa=0 wd=0xFF, rf_read_data1=0x55 -> ex_src1=0.
   - Also: id_imm_sel=1, id_imm=0xFFFF8000 -> ex_src2=0xFFFF8000.
6. Flush with MUL pending (mul_cnt=2) and consumer rs=mul_wa.
   - Required: ex_valid=0 next cycle; consumer issues the cycle after flush deasserts.
   - Also, with STALL_CNT_W=4 and 20 stall cycles: stall_cnt=15.

Source files
------------

// File: rtl/id_issue_stage.sv
// Operand-issue half of decode: resolves rs/rt through the forwarding ports,
// tracks one in-flight MUL, stalls on hazards/backpressure and drives ID/EX.
module id_issue_stage #(
  parameter int DATA_W      = 32,
  parameter int RA_W        = 5,
  parameter int NUM_FWD     = 3,
  parameter int MUL_LAT     = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst_n,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [DATA_W-1:0]         id_pc,
  input  logic [RA_W-1:0]           id_rs,
  input  logic [RA_W-1:0]           id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic [RA_W-1:0]           id_wa,
  input  logic                      id_we,
  input  logic                      id_is_load,
  input  logic                      id_is_mul,
  input  logic                      id_imm_sel,
  input  logic [DATA_W-1:0]         id_imm,
  output logic [RA_W-1:0]           rf_read_add1,
  output logic [RA_W-1:0]           rf_read_add2,
  input  logic [DATA_W-1:0]         rf_read_data1,
  input  logic [DATA_W-1:0]         rf_read_data2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*RA_W-1:0]   fwd_wa,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wd,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  input  logic                      flush,
  input  logic                      ex_ready,
  output logic                      ex_valid,
  output logic [DATA_W-1:0]         ex_pc,
  output logic [DATA_W-1:0]         ex_src1,
  output logic [DATA_W-1:0]         ex_src2,
  output logic [RA_W-1:0]           ex_wa,
  output logic                      ex_we,
  output logic                      ex_is_load,
  output logic                      ex_is_mul,
  output logic [1:0]                stall_cause,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_DATA = 2'd1;
  localparam logic [1:0] CAUSE_MUL  = 2'd2;
  localparam logic [1:0] CAUSE_BP   = 2'd3;

  typedef struct packed {
    logic              pend;
    logic [DATA_W-1:0] val;
  } opnd_t;

  // Lowest-numbered matching port wins; a match whose data is not back yet is pending.
  function automatic opnd_t resolve(input logic [RA_W-1:0] addr,
                                    input logic [DATA_W-1:0] rf_data);
    opnd_t r;
    logic  hit;
    r.pend = 1'b0;
    r.val  = rf_data;
    hit    = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_we[i] && (fwd_wa[i*RA_W +: RA_W] == addr)) begin
        hit    = 1'b1;
        r.pend = !fwd_rdy[i];
        r.val  = fwd_wd[i*DATA_W +: DATA_W];
      end
    end
    if (addr == '0) begin
      r.pend = 1'b0;
      r.val  = '0;
    end
    return r;
  endfunction

  // ID/EX bundle and bookkeeping registers
  logic                   ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]      ex_pc_q, ex_pc_d;
  logic [DATA_W-1:0]      ex_src1_q, ex_src1_d;
  logic [DATA_W-1:0]      ex_src2_q, ex_src2_d;
  logic [RA_W-1:0]        ex_wa_q, ex_wa_d;
  logic                   ex_we_q, ex_we_d;
  logic                   ex_is_load_q, ex_is_load_d;
  logic                   ex_is_mul_q, ex_is_mul_d;
  logic [RA_W-1:0]        mul_wa_q, mul_wa_d;
  logic [CNT_W-1:0]       mul_cnt_q, mul_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  opnd_t rs_r, rt_r;
  logic  data_hazard, mul_hazard, mul_busy, ex_free, fire;
  logic  mul_wa_nz;
  logic [1:0] cause;

  assign rf_read_add1 = id_rs;
  assign rf_read_add2 = id_rt;

  always_comb begin
    rs_r = resolve(id_rs, rf_read_data1);
    rt_r = resolve(id_rt, rf_read_data2);
  end

  assign data_hazard = (id_use_rs && rs_r.pend) || (id_use_rt && rt_r.pend);

  assign mul_busy  = (mul_cnt_q != '0);
  assign mul_wa_nz = (mul_wa_q != '0);
  assign mul_hazard = mul_busy &&
                      ((id_use_rs && (id_rs == mul_wa_q) && mul_wa_nz) ||
                       (id_use_rt && (id_rt == mul_wa_q) && mul_wa_nz) ||
                       (id_we && (id_wa == mul_wa_q)) ||
                       id_is_mul);

  // Handshake: a bundle moves ID->EX on id_valid && id_ready, and EX consumes
  // it on ex_valid && ex_ready; a held bundle keeps every ex_* output stable.
  assign ex_free  = !ex_valid_q || ex_ready;
  assign id_ready = ex_free && !data_hazard && !mul_hazard && !flush;
  assign fire     = id_valid && id_ready;

  always_comb begin
    cause = CAUSE_NONE;
    if (id_valid && !id_ready && !flush) begin
      if (!ex_free)         cause = CAUSE_BP;
      else if (data_hazard) cause = CAUSE_DATA;
      else if (mul_hazard)  cause = CAUSE_MUL;
      else                  cause = CAUSE_NONE;
    end
  end

  assign stall_cause = cause;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_src1_d    = ex_src1_q;
    ex_src2_d    = ex_src2_q;
    ex_wa_d      = ex_wa_q;
    ex_we_d      = ex_we_q;
    ex_is_load_d = ex_is_load_q;
    ex_is_mul_d  = ex_is_mul_q;
    if (fire) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = id_pc;
      ex_src1_d    = rs_r.val;
      ex_src2_d    = id_imm_sel ? id_imm : rt_r.val;
      ex_wa_d      = id_wa;
      ex_we_d      = id_we;
      ex_is_load_d = id_is_load;
      ex_is_mul_d  = id_is_mul;
    end else if (ex_ready || flush) begin
      ex_valid_d = 1'b0;
    end
  end

  // Flush beats a coinciding MUL load (fire is already blocked by flush).
  always_comb begin
    mul_wa_d  = mul_wa_q;
    mul_cnt_d = mul_cnt_q;
    if (flush) begin
      mul_cnt_d = '0;
    end else if (fire && id_is_mul && id_we && (id_wa != '0)) begin
      mul_wa_d  = id_wa;
      mul_cnt_d = MUL_LAT_C;
    end else if (mul_busy) begin
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((cause != CAUSE_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_src1_q    <= '0;
      ex_src2_q    <= '0;
      ex_wa_q      <= '0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_is_mul_q  <= 1'b0;
      mul_wa_q     <= '0;
      mul_cnt_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_src1_q    <= ex_src1_d;
      ex_src2_q    <= ex_src2_d;
      ex_wa_q      <= ex_wa_d;
      ex_we_q      <= ex_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_is_mul_q  <= ex_is_mul_d;
      mul_wa_q     <= mul_wa_d;
      mul_cnt_q    <= mul_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_src1    = ex_src1_q;
  assign ex_src2    = ex_src2_q;
  assign ex_wa      = ex_wa_q;
  assign ex_we      = ex_we_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_is_mul  = ex_is_mul_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios plus random traffic, checked
// against a cycle-indexed reference model with a bundle scoreboard.
module tb_id_issue_stage;

  localparam int DATA_W  = 32;
  localparam int RA_W    = 5;
  localparam int NUM_FWD = 3;
  localparam int MUL_LAT = 3;
  localparam int SCW     = 16;
  localparam int SCW_S   = 4;

  logic                      clk;
  logic                      rst_n;
  logic                      id_valid, id_ready;
  logic [DATA_W-1:0]         id_pc, id_imm;
  logic [RA_W-1:0]           id_rs, id_rt, id_wa;
  logic                      id_use_rs, id_use_rt, id_we, id_is_load, id_is_mul, id_imm_sel;
  logic [RA_W-1:0]           rf_read_add1, rf_read_add2;
  logic [DATA_W-1:0]         rf_read_data1, rf_read_data2;
  logic [NUM_FWD-1:0]        fwd_we, fwd_rdy;
  logic [RA_W-1:0]           f_wa [NUM_FWD];
  logic [DATA_W-1:0]         f_wd [NUM_FWD];
  logic [NUM_FWD*RA_W-1:0]   fwd_wa;
  logic [NUM_FWD*DATA_W-1:0] fwd_wd;
  logic                      flush, ex_ready, ex_valid;
  logic [DATA_W-1:0]         ex_pc, ex_src1, ex_src2;
  logic [RA_W-1:0]           ex_wa;
  logic                      ex_we, ex_is_load, ex_is_mul;
  logic [1:0]                stall_cause;
  logic [SCW-1:0]            stall_cnt;

  // Narrow-counter instance shares all inputs; only its stall_cnt is of interest.
  logic                      s_id_ready, s_ex_valid, s_ex_we, s_ex_is_load, s_ex_is_mul;
  logic [RA_W-1:0]           s_rf_add1, s_rf_add2, s_ex_wa;
  logic [DATA_W-1:0]         s_ex_pc, s_ex_src1, s_ex_src2;
  logic [1:0]                s_stall_cause;
  logic [SCW_S-1:0]          s_stall_cnt;

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_pack
    assign fwd_wa[g*RA_W +: RA_W]     = f_wa[g];
    assign fwd_wd[g*DATA_W +: DATA_W] = f_wd[g];
  end

  id_issue_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD), .MUL_LAT(MUL_LAT),
                   .STALL_CNT_W(SCW)) u_dut (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wa(id_wa), .id_we(id_we), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .id_imm_sel(id_imm_sel), .id_imm(id_imm), .rf_read_add1(rf_read_add1),
    .rf_read_add2(rf_read_add2), .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_wd(fwd_wd), .fwd_rdy(fwd_rdy), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_wa(ex_wa), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_is_mul(ex_is_mul), .stall_cause(stall_cause), .stall_cnt(stall_cnt)
  );

  id_issue_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD), .MUL_LAT(MUL_LAT),
                   .STALL_CNT_W(SCW_S)) u_dut_s (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .id_valid(id_valid), .id_ready(s_id_ready),
    .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wa(id_wa), .id_we(id_we), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .id_imm_sel(id_imm_sel), .id_imm(id_imm), .rf_read_add1(s_rf_add1),
    .rf_read_add2(s_rf_add2), .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_wd(fwd_wd), .fwd_rdy(fwd_rdy), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_src1(s_ex_src1),
    .ex_src2(s_ex_src2), .ex_wa(s_ex_wa), .ex_we(s_ex_we), .ex_is_load(s_ex_is_load),
    .ex_is_mul(s_ex_is_mul), .stall_cause(s_stall_cause), .stall_cnt(s_stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [RA_W-1:0]   wa;
    logic              we;
    logic              ld;
    logic              mul;
    logic              c1;
    logic              c2;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int          cyc = 0;
  int          m_mul_free = 0;       // first cycle in which the MUL no longer blocks
  logic [RA_W-1:0] m_mul_wa = '0;
  logic        m_ex_valid = 1'b0;
  int unsigned m_stall = 0;
  logic        last_ready;
  logic [1:0]  last_cause;

  // Returns {pending, value} for a source register using the forwarding rules.
  function automatic logic [DATA_W:0] m_resolve(input logic [RA_W-1:0] a,
                                                input logic [DATA_W-1:0] rf);
    if (a == 0) return {1'b0, {DATA_W{1'b0}}};
    for (int p = 0; p < NUM_FWD; p++)
      if (fwd_we[p] && f_wa[p] == a) return {!fwd_rdy[p], f_wd[p]};
    return {1'b0, rf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_valid = 0; id_pc = '0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_wa = '0; id_we = 0; id_is_load = 0; id_is_mul = 0; id_imm_sel = 0; id_imm = '0;
    rf_read_data1 = $urandom; rf_read_data2 = $urandom;
    fwd_we = '0; fwd_rdy = '1; flush = 0; ex_ready = 1;
    for (int p = 0; p < NUM_FWD; p++) begin f_wa[p] = '0; f_wd[p] = '0; end
  endtask

  task automatic rand_inputs();
    id_valid   = ($urandom_range(0, 9) < 8);
    id_pc      = $urandom;
    id_rs      = RA_W'($urandom_range(0, 7));
    id_rt      = RA_W'($urandom_range(0, 7));
    id_use_rs  = $urandom_range(0, 1);
    id_use_rt  = $urandom_range(0, 1);
    id_wa      = RA_W'($urandom_range(0, 7));
    id_we      = ($urandom_range(0, 3) != 0);
    id_is_mul  = ($urandom_range(0, 4) == 0);
    id_is_load = !id_is_mul && ($urandom_range(0, 3) == 0);
    id_imm_sel = $urandom_range(0, 1);
    id_imm     = $urandom;
    rf_read_data1 = $urandom;
    rf_read_data2 = $urandom;
    for (int p = 0; p < NUM_FWD; p++) begin
      fwd_we[p]  = $urandom_range(0, 1);
      fwd_rdy[p] = ($urandom_range(0, 3) != 0);
      f_wa[p]    = RA_W'($urandom_range(0, 7));
      f_wd[p]    = $urandom;
    end
    flush    = ($urandom_range(0, 19) == 0);
    ex_ready = ($urandom_range(0, 9) < 7);
  endtask

  // Called at posedge+1 with inputs set; checks this cycle and advances one edge.
  task automatic tick();
    logic [DATA_W:0] r1, r2;
    logic dh, mh, busy, efree, rdy, fire;
    logic [1:0] cause;
    exp_t e;
    int unsigned sat_s;
    #1;
    r1    = m_resolve(id_rs, rf_read_data1);
    r2    = m_resolve(id_rt, rf_read_data2);
    dh    = (id_use_rs && r1[DATA_W]) || (id_use_rt && r2[DATA_W]);
    busy  = (cyc < m_mul_free);
    mh    = busy && ((id_use_rs && id_rs == m_mul_wa && m_mul_wa != 0) ||
                     (id_use_rt && id_rt == m_mul_wa && m_mul_wa != 0) ||
                     (id_we && id_wa == m_mul_wa) || id_is_mul);
    efree = !m_ex_valid || ex_ready;
    rdy   = efree && !dh && !mh && !flush;
    fire  = id_valid && rdy;
    cause = 2'd0;
    if (id_valid && !rdy && !flush) cause = !efree ? 2'd3 : dh ? 2'd1 : 2'd2;
    sat_s = (m_stall > 15) ? 15 : m_stall;

    chk("id_ready", 64'(id_ready), 64'(rdy));
    chk("stall_cause", 64'(stall_cause), 64'(cause));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("stall_cnt_w4", 64'(s_stall_cnt), 64'(sat_s));
    chk("ex_valid", 64'(ex_valid), 64'(m_ex_valid));
    chk("rf_read_add", 64'({rf_read_add1, rf_read_add2}), 64'({id_rs, id_rt}));
    last_ready = id_ready;
    last_cause = stall_cause;

    if (fire) begin
      e.pc = id_pc; e.src1 = r1[DATA_W-1:0];
      e.src2 = id_imm_sel ? id_imm : r2[DATA_W-1:0];
      e.wa = id_wa; e.we = id_we; e.ld = id_is_load; e.mul = id_is_mul;
      e.c1 = !r1[DATA_W]; e.c2 = id_imm_sel || !r2[DATA_W];
      exp_q.push_back(e);
    end
    if (cause != 0 && m_stall < (2**SCW) - 1) m_stall++;
    if (fire) m_ex_valid = 1'b1;
    else if (ex_ready || flush) m_ex_valid = 1'b0;
    if (flush) m_mul_free = cyc + 1;
    else if (fire && id_is_mul && id_we && id_wa != 0) begin
      m_mul_wa = id_wa;
      m_mul_free = cyc + MUL_LAT + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_bundle", 64'({ex_pc, ex_wa, ex_we, ex_is_load, ex_is_mul}), 64'd0);
    chk("rst_ex_srcs", {ex_src1, ex_src2}, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_stall_cause", 64'(stall_cause), 64'd0);
    m_ex_valid = 1'b0; m_mul_free = 0; m_mul_wa = '0; m_stall = 0; cyc = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (rst_n && ex_valid && (ex_ready || flush)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bundle", 64'(ex_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ex_pc", 64'(ex_pc), 64'(e.pc));
          if (e.c1) chk("ex_src1", 64'(ex_src1), 64'(e.src1));
          if (e.c2) chk("ex_src2", 64'(ex_src2), 64'(e.src2));
          chk("ex_flags", 64'({ex_wa, ex_we, ex_is_load, ex_is_mul}),
              64'({e.wa, e.we, e.ld, e.mul}));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit done;
    do_reset();

    // forwarding priority: port 0 beats port 1
    set_idle();
    fwd_we = 3'b011; f_wa[0] = 5; f_wd[0] = 32'h11; f_wa[1] = 5; f_wd[1] = 32'h22;
    id_valid = 1; id_pc = 32'h100; id_rs = 5; id_use_rs = 1;
    tick();
    chk("t1_ex_valid", 64'(ex_valid), 64'd1);
    chk("t1_src1", 64'(ex_src1), 64'h11);

    // load-use hazard then data returns
    set_idle();
    fwd_we[0] = 1; f_wa[0] = 8; fwd_rdy[0] = 0;
    id_valid = 1; id_pc = 32'h200; id_rs = 8; id_use_rs = 1;
    repeat (3) begin
      tick();
      chk("t2_cause", 64'(last_cause), 64'd1);
    end
    fwd_rdy[0] = 1; f_wd[0] = 32'hAB;
    tick();
    chk("t2_src1", 64'(ex_src1), 64'hAB);

    // MUL then dependent consumer, then MUL then second MUL
    for (int v = 0; v < 2; v++) begin
      set_idle();
      id_valid = 1; id_pc = 32'h300; id_is_mul = 1; id_we = 1; id_wa = 9;
      tick();
      id_pc = 32'h304; id_we = 1;
      if (v == 0) begin id_is_mul = 0; id_rs = 9; id_use_rs = 1; id_wa = 10; end
      else begin id_is_mul = 1; id_wa = 12; end
      n = 0; done = 0;
      for (int k = 0; k < 8 && !done; k++) begin
        tick();
        if (last_ready) done = 1;
        else if (last_cause == 2'd2) n++;
      end
      chk("t3_mul_stall_len", 64'(n), 64'(MUL_LAT));
      set_idle();
      repeat (MUL_LAT + 1) tick();
    end

    // backpressure holds the bundle
    set_idle();
    id_valid = 1; id_pc = 32'h400; id_wa = 3; id_we = 1;
    tick();
    ex_ready = 0; id_pc = 32'h404;
    repeat (4) begin
      tick();
      chk("t4_cause", 64'(last_cause), 64'd3);
      chk("t4_hold_pc", 64'(ex_pc), 64'h400);
    end
    ex_ready = 1;
    tick();

    // zero register and immediate select
    set_idle();
    fwd_we[0] = 1; f_wa[0] = 0; f_wd[0] = 32'hFF;
    rf_read_data1 = 32'h55;
    id_valid = 1; id_pc = 32'h500; id_rs = 0; id_use_rs = 1;
    id_imm_sel = 1; id_imm = 32'hFFFF8000;
    tick();
    chk("t5_src1_zero", 64'(ex_src1), 64'd0);
    chk("t5_src2_imm", 64'(ex_src2), 64'hFFFF8000);

    // flush while a MUL is pending and the consumer waits on it
    set_idle();
    id_valid = 1; id_pc = 32'h600; id_is_mul = 1; id_we = 1; id_wa = 9;
    tick();
    id_is_mul = 0; id_pc = 32'h604; id_rs = 9; id_use_rs = 1; id_wa = 11;
    tick();
    flush = 1;
    tick();
    chk("t6_flush_ready", 64'(last_ready), 64'd0);
    chk("t6_flush_ex_valid", 64'(ex_valid), 64'd0);
    flush = 0;
    tick();
    chk("t6_after_flush_ready", 64'(last_ready), 64'd1);

    // long backpressure saturates the narrow counter
    set_idle();
    id_valid = 1; id_pc = 32'h700;
    tick();
    ex_ready = 0;
    repeat (20) tick();
    chk("t6_sat_w4", 64'(s_stall_cnt), 64'd15);
    set_idle();
    tick();

    // random traffic, reset mid-operation, more random traffic
    repeat (300) begin rand_inputs(); tick(); end
    do_reset();
    repeat (300) begin rand_inputs(); tick(); end

    set_idle();
    repeat (MUL_LAT + 4) tick();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
